// File: rtl/aoi_stim_gen.sv
// aoi_stim_gen: steps the AOI inputs {D,C,B,A} through all 16 codes with run/pause/step/loop control
module aoi_stim_gen #(
  parameter int HOLD_CYCLES = 50,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       gray_mode,
  input  logic       loop_en,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [3:0] pattern_idx,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d, code_q, code_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             busy_q, busy_d, done_q, done_d, at_end;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    at_end  = idx_q == 4'd15 && !loop_en;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RUN;
        idx_d   = '0;
        hold_d  = '0;
      end
      RUN: if (stop) state_d = PAUSE;
        else if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          idx_d   = at_end ? idx_q : idx_q + 4'd1;
          state_d = at_end ? DONE : RUN;
        end else hold_d = hold_q + CNT_W'(1);
      PAUSE: if (start) state_d = RUN;
        else if (step) begin
          hold_d  = '0;
          idx_d   = at_end ? idx_q : idx_q + 4'd1;
          state_d = at_end ? DONE : PAUSE;
        end
    endcase
    code_d = gray_mode ? idx_d ^ (idx_d >> 1) : idx_d;
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      code_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign {D, C, B, A} = code_q;
  assign pattern_idx  = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_aoi_stim_gen.sv
// tb_aoi_stim_gen: directed checks of aoi_stim_gen with HOLD_CYCLES=4
module tb_aoi_stim_gen;
  logic clk = 1'b0, rst, start, stop, step, gray_mode, loop_en;
  logic a, b, c, d, busy, done;
  logic [3:0] pidx, abcd, prev;
  int n_tests = 0, n_fail = 0;
  logic [3:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  aoi_stim_gen #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .gray_mode(gray_mode), .loop_en(loop_en), .A(a), .B(b), .C(c), .D(d),
    .pattern_idx(pidx), .busy(busy), .done(done)
  );
  assign abcd = {d, c, b, a};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; start = 0; stop = 0; step = 0; gray_mode = 0; loop_en = 0;
    #12;
    chk("rst_abcd", abcd, 0); chk("rst_idx", pidx, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    stop = 1; step = 1; tick(); stop = 0; step = 0;
    chk("idle_ignore_idx", pidx, 0); chk("idle_ignore_busy", busy, 0);
    // binary single pass
    start = 1; tick(); start = 0;
    for (int i = 0; i < 64; i++) begin
      chk("bin_idx", pidx, i / 4); chk("bin_abcd", abcd, i / 4); chk("bin_busy", busy, 1);
      tick();
    end
    chk("bin_done", done, 1); chk("bin_busy_end", busy, 0); chk("bin_final", abcd, 15);
    step = 1; tick(); step = 0;
    chk("done_ignore_step", pidx, 15); chk("done_hold", done, 1);
    // gray single pass
    gray_mode = 1; start = 1; tick(); start = 0;
    chk("gray_done_clr", done, 0);
    prev = abcd;
    for (int i = 0; i < 64; i++) begin
      chk("gray_abcd", abcd, gray_tbl[i / 4]);
      if (i % 4 == 0 && i > 0) chk("gray_onebit", $countones(prev ^ abcd), 1);
      prev = abcd;
      tick();
    end
    chk("gray_done", done, 1); chk("gray_final", abcd, 8);
    // looping run; a start pulse mid-run must not restart
    gray_mode = 0; loop_en = 1; start = 1; tick(); start = 0;
    for (int i = 0; i < 70; i++) begin
      chk("loop_idx", pidx, (i / 4) % 16); chk("loop_busy", busy, 1); chk("loop_done", done, 0);
      start = (i == 10);
      tick();
    end
    start = 0;
    // stop colliding with the 5->6 advance
    rst = 1; #1 rst = 0; loop_en = 0;
    @(negedge clk);
    start = 1; tick(); start = 0;
    repeat (23) tick();
    chk("pre_stop_idx", pidx, 5);
    stop = 1; tick(); stop = 0;
    chk("stop_idx", pidx, 5); chk("stop_busy", busy, 0); chk("stop_done", done, 0);
    tick();
    chk("pause_hold", pidx, 5);
    repeat (3) begin step = 1; tick(); step = 0; tick(); end
    chk("step_idx", pidx, 8); chk("step_abcd", abcd, 8);
    start = 1; step = 1; tick(); start = 0; step = 0;
    chk("resume_busy", busy, 1); chk("resume_idx", pidx, 8);
    repeat (3) tick();
    chk("resume_hold", pidx, 8);
    tick();
    chk("resume_adv", pidx, 9);
    // step off the end of the sequence
    stop = 1; tick(); stop = 0;
    repeat (6) begin step = 1; tick(); step = 0; end
    chk("pause15_idx", pidx, 15); chk("pause15_done", done, 0);
    step = 1; tick(); step = 0;
    chk("step_done", done, 1); chk("step_done_abcd", abcd, 15); chk("step_done_busy", busy, 0);
    start = 1; tick(); start = 0;
    chk("restart_abcd", abcd, 0); chk("restart_busy", busy, 1); chk("restart_done", done, 0);
    // asynchronous reset between edges
    repeat (36) tick();
    chk("pre_rst_idx", pidx, 9);
    #2 rst = 1;
    #1;
    chk("arst_idx", pidx, 0); chk("arst_abcd", abcd, 0);
    chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    rst = 0;
    @(negedge clk);
    repeat (5) tick();
    chk("post_rst_busy", busy, 0); chk("post_rst_idx", pidx, 0);
    start = 1; tick(); start = 0;
    chk("post_rst_start", busy, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
